// File: rtl/jk_arb_pkg.sv
// Shared types for the JK bank arbiter: FSM states, JK op codes and the
// captured command record.
package jk_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  // {J,K} encoding of a bank command
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  // Widest bank the command record can describe; narrower banks zero-extend.
  localparam int JK_MAX_WIDTH = 64;

  typedef struct packed {
    logic [1:0]              op;
    logic [JK_MAX_WIDTH-1:0] mask;
  } jk_cmd_t;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop of the shared bank; en qualifies the J/K inputs so the
// cell holds whenever its bit is not being written.
module jk_cell
  import jk_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  input  logic en,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // bank samples its pre-edge value regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        OP_CLR:  q <= 1'b0;
        OP_SET:  q <= 1'b1;
        OP_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one requester at a time a 2-cycle command
// slot on a shared bank of JK cells. Define JK_ARB_LOCK_EN to add req_lock.
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_mask,
`ifdef JK_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_lock,
`endif
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NREQ);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] rr_next;
  logic             any_valid;
  logic             accept;
  logic             apply;
  jk_cmd_t          cmd_q;
  logic [WIDTH-1:0] cell_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case/if tree can leave a signal unassigned and infer a latch.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = rr_ptr;
    any_valid = 1'b0;
    // Walk downward so the last hit is the one closest to rr_ptr.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        winner    = IDX_W'(idx);
        any_valid = 1'b1;
      end
    end

    rr_next = IDX_W'((int'(winner) + 1) % NREQ);
`ifdef JK_ARB_LOCK_EN
    if (req_lock[winner]) rr_next = winner;
`endif

    accept    = rst_n && (state_q == IDLE) && any_valid;
    req_ready = accept ? (NREQ'(1) << winner) : '0;

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured command is reset along with the pointer so an APPLY
  // aborted by reset leaves no stale op or mask behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      cmd_q    <= '0;
    end else if (accept) begin
      rr_ptr     <= rr_next;
      grant_id   <= winner;
      cmd_q.op   <= req_op[2*int'(winner) +: 2];
      cmd_q.mask <= JK_MAX_WIDTH'(req_mask[WIDTH*int'(winner) +: WIDTH]);
    end
  end

  assign apply = (state_q == APPLY);
  assign busy  = apply;

  always_comb begin
    cell_en = '0;
    for (int i = 0; i < WIDTH; i++) cell_en[i] = apply && cmd_q.mask[i];
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (cell_en[g] & cmd_q.op[1]),
      .k     (cell_en[g] & cmd_q.op[0]),
      .en    (cell_en[g]),
      .q     (q[g])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: expected grants and resulting bank
// values are queued as stimulus is driven and retired by a negedge monitor.
`timescale 1ns/1ps
module tb_jk_bank_arbiter;
  import jk_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDX_W = $clog2(NREQ);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [2*NREQ-1:0]       req_op = '0;
  logic [WIDTH*NREQ-1:0]   req_mask = '0;
`ifdef JK_ARB_LOCK_EN
  logic [NREQ-1:0]         req_lock = '0;
`endif
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        q;
  logic [IDX_W-1:0]        grant_id;
  logic                    busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] q;
  } exp_t;

  exp_t sb[$];
  exp_t s1, s2;
  bit   s1_v = 1'b0;
  bit   s2_v = 1'b0;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_mask  (req_mask),
`ifdef JK_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .q         (q),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Monitor: grant cycle -> apply cycle -> bank value, sampled at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s1_v = 1'b0;
        s2_v = 1'b0;
      end else begin
        if (s2_v) begin
          total_cnt++;
          if (q !== s2.q)
            $display("FAIL q_after_apply[req%0d]: got %h expected %h", s2.id, q, s2.q);
          else pass_cnt++;
          s2_v = 1'b0;
        end
        if (s1_v) begin
          total_cnt++;
          if (busy !== 1'b1 || grant_id !== IDX_W'(s1.id) || req_ready !== '0)
            $display("FAIL apply_cycle[req%0d]: busy=%b grant_id=%0d ready=%b expected busy=1 grant_id=%0d ready=0",
                     s1.id, busy, grant_id, req_ready, s1.id);
          else pass_cnt++;
          s2   = s1;
          s2_v = 1'b1;
          s1_v = 1'b0;
        end
        if (req_ready !== '0) begin
          total_cnt++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_grant: ready=%b expected none", req_ready);
          end else begin
            e = sb.pop_front();
            if (req_ready !== (NREQ'(1) << e.id))
              $display("FAIL grant_order: ready=%b expected %b", req_ready, NREQ'(1) << e.id);
            else pass_cnt++;
            s1   = e;
            s1_v = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_exp(input int id, input logic [WIDTH-1:0] qv);
    exp_t e;
    e.id = id;
    e.q  = qv;
    sb.push_back(e);
  endtask

  task automatic set_cmd(input int id, input logic [1:0] op, input logic [WIDTH-1:0] mask);
    req_op[2*id +: 2]         = op;
    req_mask[WIDTH*id +: WIDTH] = mask;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_mask  = '0;
`ifdef JK_ARB_LOCK_EN
    req_lock  = '0;
`endif
    sb.delete();
    idle(2);
    rst_n = 1'b1;
  endtask

  // Hold the given requesters valid, dropping each one (and scrambling its
  // op/mask) in the cycle after its accept pulse.
  task automatic serve(input logic [NREQ-1:0] bits, input int budget);
    logic [NREQ-1:0] left;
    logic [NREQ-1:0] seen;
    int n;
    left      = bits;
    n         = 0;
    req_valid = req_valid | bits;
    while (left != '0 && n < budget) begin
      @(negedge clk);
      seen = req_ready & left;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~seen;
      left      = left & ~seen;
      for (int i = 0; i < NREQ; i++) begin
        if (seen[i]) begin
          req_op[2*i +: 2]           = ~req_op[2*i +: 2];
          req_mask[WIDTH*i +: WIDTH] = ~req_mask[WIDTH*i +: WIDTH];
        end
      end
      n++;
    end
    if (left != '0) begin
      total_cnt++;
      $display("FAIL serve_timeout: pending=%b expected none", left);
      req_valid = req_valid & ~left;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || s1_v || s2_v) && n < budget) begin
      idle(1);
      n++;
    end
    if (sb.size() != 0 || s1_v || s2_v) begin
      total_cnt++;
      $display("FAIL drain_timeout: outstanding=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    req_op    = '1;
    req_mask  = '1;
    idle(2);
    @(negedge clk);
    total_cnt++;
    if (q !== '0) $display("FAIL reset_q: got %h expected 00", q); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (req_ready !== '0) $display("FAIL reset_ready: got %b expected 0000", req_ready); else pass_cnt++;
    total_cnt++;
    if (grant_id !== '0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id); else pass_cnt++;
    do_reset();
    idle(2);
    @(negedge clk);
    total_cnt++;
    if (req_ready !== '0 || busy !== 1'b0)
      $display("FAIL idle_no_request: ready=%b busy=%b expected ready=0000 busy=0", req_ready, busy);
    else pass_cnt++;
    idle(1);
  endtask

  task automatic test_single();
    do_reset();
    set_cmd(0, OP_SET, 8'h0F);
    push_exp(0, 8'h0F);
    req_valid = 4'b0001;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 4'b0001 || q !== 8'h00)
      $display("FAIL single_cycle1: ready=%b q=%h expected ready=0001 q=00", req_ready, q);
    else pass_cnt++;
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || q !== 8'h00)
      $display("FAIL single_cycle2: busy=%b q=%h expected busy=1 q=00", busy, q);
    else pass_cnt++;
    @(posedge clk);
    #1;
    @(negedge clk);
    total_cnt++;
    if (q !== 8'h0F || busy !== 1'b0)
      $display("FAIL single_cycle3: q=%h busy=%b expected q=0f busy=0", q, busy);
    else pass_cnt++;
    idle(1);
    drain(6);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cmd(i, OP_TGL, WIDTH'(1) << i);
    push_exp(0, 8'h01);
    push_exp(1, 8'h03);
    push_exp(2, 8'h07);
    push_exp(3, 8'h0F);
    push_exp(0, 8'h0E);
    req_valid = '1;
    idle(9);
    req_valid = '0;
    drain(10);
    // Idle cycles leave the pointer at 1, so requester 3 beats requester 0.
    idle(3);
    set_cmd(3, OP_SET, 8'h10);
    set_cmd(0, OP_SET, 8'h20);
    push_exp(3, 8'h1E);
    push_exp(0, 8'h3E);
    serve(4'b1001, 12);
    drain(10);
  endtask

  task automatic test_clear_hold();
    do_reset();
    set_cmd(0, OP_SET, 8'hFF);
    push_exp(0, 8'hFF);
    serve(4'b0001, 8);
    set_cmd(1, OP_CLR, 8'hA5);
    push_exp(1, 8'h5A);
    serve(4'b0010, 8);
    set_cmd(2, OP_HOLD, 8'hFF);
    push_exp(2, 8'h5A);
    serve(4'b0100, 8);
    set_cmd(3, OP_TGL, 8'h00);
    push_exp(3, 8'h5A);
    serve(4'b1000, 8);
    drain(10);
  endtask

  task automatic test_drop_before_ready();
    do_reset();
    set_cmd(0, OP_SET, 8'h01);
    push_exp(0, 8'h01);
    serve(4'b0001, 8);
    set_cmd(2, OP_SET, 8'h80);
    req_valid[2] = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== '0 || busy !== 1'b1)
      $display("FAIL apply_blocks_grant: ready=%b busy=%b expected ready=0000 busy=1", req_ready, busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    drain(8);
    idle(3);
    @(negedge clk);
    total_cnt++;
    if (q !== 8'h01) $display("FAIL dropped_request_q: got %h expected 01", q); else pass_cnt++;
    idle(1);
  endtask

  task automatic test_reset_mid_apply();
    do_reset();
    set_cmd(3, OP_SET, 8'h3C);
    push_exp(3, 8'h3C);
    serve(4'b1000, 8);
    drain(8);
    set_cmd(1, OP_SET, 8'hFF);
    push_exp(1, 8'hFF);
    serve(4'b0010, 8);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (q !== 8'h00 || busy !== 1'b0)
      $display("FAIL reset_mid_apply: q=%h busy=%b expected q=00 busy=0", q, busy);
    else pass_cnt++;
    sb.delete();
    @(posedge clk);
    #1;
    total_cnt++;
    if (q !== 8'h00) $display("FAIL reset_no_partial: got %h expected 00", q); else pass_cnt++;
    rst_n = 1'b1;
    set_cmd(0, OP_SET, 8'h01);
    set_cmd(2, OP_SET, 8'h04);
    push_exp(0, 8'h01);
    push_exp(2, 8'h05);
    serve(4'b0101, 12);
    drain(10);
  endtask

`ifdef JK_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req_lock = 4'b0010;
    set_cmd(1, OP_TGL, 8'h01);
    set_cmd(2, OP_SET, 8'h80);
    push_exp(1, 8'h01);
    push_exp(1, 8'h00);
    push_exp(1, 8'h01);
    push_exp(2, 8'h81);
    req_valid = 4'b0110;
    idle(5);
    req_valid[1] = 1'b0;
    serve(4'b0100, 10);
    drain(10);
    req_lock = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clear_hold();
    test_drop_before_ready();
    test_reset_mid_apply();
`ifdef JK_ARB_LOCK_EN
    test_lock();
`endif
    idle(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 The parameter NREQ SHALL default to 4 and set the number of requesters (2..8).
REQ-002 The parameter WIDTH SHALL default to 8 and set the number of JK cells in the shared bank.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset.
REQ-005 The port req_valid SHALL be an input, NREQ bits wide, with bit i set when requester i holds a pending command.
REQ-006 The port req_op SHALL be an input, 2*NREQ bits wide, carrying the {J,K} command of requester i in bits [2i+1:2i].
REQ-007 The port req_mask SHALL be an input, WIDTH*NREQ bits wide, carrying the cell-select mask of requester i in bits [WIDTH*i +: WIDTH].
REQ-008 The port req_ready SHALL be an output, NREQ bits wide, giving a one-hot accept pulse.
REQ-009 The port q SHALL be an output, WIDTH bits wide, giving the current state of the JK bank.
REQ-010 The port grant_id SHALL be an output, $clog2(NREQ) bits wide, giving the index of the last accepted requester.
REQ-011 The port busy SHALL be an output, 1 bit wide, high while a command is being applied.

Function
REQ-012 The {J,K} op encoding SHALL be: 00 = hold, 01 = clear to 0, 10 = set to 1, 11 = toggle.
REQ-013 The FSM SHALL have exactly two states, IDLE and APPLY.
REQ-014 In IDLE with any req_valid bit high, the block SHALL select a winner by round-robin starting at pointer rr_ptr, capture that winner's op and mask, pulse req_ready[winner] for that cycle, update grant_id, and go to APPLY.
REQ-015 In IDLE with no req_valid bit high, the FSM SHALL stay in IDLE, req_ready SHALL be all zero, and rr_ptr SHALL be unchanged.
REQ-016 After a grant, rr_ptr SHALL become (winner+1) mod NREQ.
REQ-017 In APPLY, busy SHALL be 1 and req_ready SHALL be all zero.
REQ-018 In APPLY, each q bit with its mask bit set SHALL update per the captured op at the end of the cycle; unmasked bits SHALL hold.
REQ-019 From APPLY the FSM SHALL always return to IDLE.
REQ-020 As a result, latency SHALL be 2 cycles (q changes at the edge ending APPLY) and peak throughput SHALL be one command per 2 cycles.
REQ-021 req_valid that drops before its req_ready pulse SHALL be discarded without a grant.
REQ-022 Op and mask SHALL be sampled only in the accept cycle; later changes SHALL NOT affect the command in flight.
REQ-023 A mask of all zeros SHALL still be granted and consume an APPLY cycle, with no change to q.

Reset
REQ-024 While rst_n is low, the block SHALL asynchronously force q=0, state=IDLE, rr_ptr=0, grant_id=0, req_ready=0, busy=0, and clear the captured op and mask.
REQ-025 Reset asserted during APPLY SHALL abort the command with no partial q update.
REQ-026 After rst_n deasserts, the first grant SHALL start its priority search at requester 0.

Configuration
REQ-027 With macro JK_ARB_LOCK_EN defined, the block SHALL add an input req_lock (NREQ bits); a winner whose lock bit is set at accept SHALL keep priority (rr_ptr=winner) for its next request.
REQ-028 Without JK_ARB_LOCK_EN, the req_lock port SHALL be absent and arbitration SHALL be pure round-robin.
REQ-029 Locking SHALL NOT bypass the 2-cycle APPLY sequence; other requesters SHALL be granted as soon as the lock holder's req_valid is low in IDLE.

Structure
REQ-030 A shared package jk_arb_pkg SHALL hold the state enum (IDLE/APPLY), the op-code localparams (OP_HOLD, OP_CLR, OP_SET, OP_TGL), and a jk_cmd_t struct {op, mask}.
REQ-031 The JK bank SHALL be built from WIDTH instances of a sub-module jk_cell (J, K, en, clk, rst_n -> Q, with async active-low reset to 0), with J/K gated by the mask and the APPLY state.

Verification
REQ-032 After reset, a single request (req_valid=0001, op=10, mask=0x0F) SHALL produce req_ready=0001 in cycle 1, busy in cycle 2, and q=0x0F from cycle 3.
REQ-033 With all four requesters held valid (toggle, masks 0x01/0x02/0x04/0x08), grants SHALL run in the order 0,1,2,3,0 at 2-cycle spacing, and q SHALL read 0x01, 0x03, 0x07, 0x0F, 0x0E.
REQ-034 From q=0xFF, an op=01 clear with mask 0xA5 SHALL give q=0x5A, and a following op=00 hold with mask 0xFF SHALL leave q=0x5A.
REQ-035 Asserting rst_n low mid-APPLY (set, mask 0xFF) SHALL give q=0x00 immediately, and after release the next grant SHALL go to requester 0 ahead of requester 2.
REQ-036 With JK_ARB_LOCK_EN defined and requester 1 locked and valid continuously, requester 1 SHALL be granted back-to-back; after it drops req_valid, requester 2 SHALL be granted next.
